// File: rtl/conv_core.sv
// conv_core: streaming sliding-window multiply-accumulate.
// Two parallel TAPS-deep delay lines carry the sample pairs. Each tap pair is
// multiplied at full precision, then the products are summed at a width that
// cannot wrap. The sum is clamped to the 2*DW-bit signed range and registered.
// The path from input capture to output is three register stages.
module conv_core #(
  parameter int DW   = 12,
  parameter int TAPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   CONV_iData0,
  input  logic [DW-1:0]   CONV_iData1,
  output logic [2*DW-1:0] CONV_oData
);

  localparam int PW = 2 * DW;               // product / output width
  localparam int SW = PW + $clog2(TAPS);    // accumulator width, wrap-free

  // Clamp bounds, sign-extended to the accumulator width.
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-PW+1){1'b1}}, {(PW-1){1'b0}}};

  logic signed [DW-1:0] r_x [TAPS];
  logic signed [DW-1:0] r_h [TAPS];
  logic signed [PW-1:0] r_p [TAPS];
  logic signed [SW-1:0] w_sum;
  logic        [PW-1:0] w_sat;
  logic        [PW-1:0] r_out;

  // Stage 1: shift both delay lines and capture the new pair at tap 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_h[k] <= '0;
      end
    end else begin
      r_x[0] <= CONV_iData0;
      r_h[0] <= CONV_iData1;
      for (int k = 1; k < TAPS; k++) begin
        r_x[k] <= r_x[k-1];
        r_h[k] <= r_h[k-1];
      end
    end
  end

  // Stage 2: element-wise full-precision products.
  // Sign-extend both operands first so the multiply runs at the product width.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        r_p[k] <= PW'(r_x[k]) * PW'(r_h[k]);
      end
    end
  end

  // Sum the products at the widened accumulator width.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + SW'(r_p[k]);
    end
  end

  // Clamp the wide sum into the signed output range.
  always_comb begin
    w_sat = w_sum[PW-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = {1'b0, {(PW-1){1'b1}}};
    end else if (w_sum < SAT_MIN) begin
      w_sat = {1'b1, {(PW-1){1'b0}}};
    end
  end

  // Stage 3: register the saturated sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_sat;
    end
  end

  assign CONV_oData = r_out;

endmodule

// File: tb/tb_conv_core.sv
// Testbench for conv_core.
// A table of directed vectors covers ramps, window exit, saturation and
// mid-stream reset. A long hand-written reset hold precedes the table, and a
// randomized phase is checked against a product-history reference model.
module tb_conv_core;

  localparam int DW   = 12;
  localparam int TAPS = 4;

  logic            clk;
  logic            reset;
  logic [DW-1:0]   d0;
  logic [DW-1:0]   d1;
  logic [2*DW-1:0] dout;

  int checks   = 0;
  int failures = 0;

  conv_core #(.DW(DW), .TAPS(TAPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .CONV_iData0(d0),
    .CONV_iData1(d1),
    .CONV_oData (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the products of the pairs captured at recent edges,
  // newest first. A reset edge wipes the history back to zeros.
  longint prod_q[$];
  longint sat_hi;
  longint sat_lo;

  function automatic longint model_out();
    longint s;
    s = 0;
    for (int j = 2; j <= TAPS + 1; j++) s += prod_q[j];
    if (s > sat_hi) s = sat_hi;
    if (s < sat_lo) s = sat_lo;
    return s;
  endfunction

  task automatic model_clear();
    prod_q.delete();
    for (int j = 0; j < TAPS + 2; j++) prod_q.push_back(0);
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end else begin
      $display("ok   %s got=%0d", nm, act);
    end
  endtask

  // Apply one input set for one clock edge, sample after the edge and advance the model.
  task automatic step(input logic rst, input int a, input int b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    sa = a[DW-1:0];
    sb = b[DW-1:0];
    reset = rst;
    d0 = sa;
    d1 = sb;
    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else begin
      prod_q.push_front(longint'(sa) * longint'(sb));
      void'(prod_q.pop_back());
    end
  endtask

  function automatic longint out_s();
    return longint'($signed(dout));
  endfunction

  typedef struct {
    logic rst;
    int   a;
    int   b;
    int   exp;
    int   id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input int a, input int b, input int exp, input int id);
    vec_t v;
    v.rst = rst; v.a = a; v.b = b; v.exp = exp; v.id = id;
    vecs.push_back(v);
  endtask

  initial begin
    sat_hi = (longint'(1) << (2*DW-1)) - 1;
    sat_lo = -(longint'(1) << (2*DW-1));
    model_clear();
    reset = 1'b1;
    d0 = '0;
    d1 = '0;

    // Reset held for a long stretch with arbitrary inputs.
    for (int i = 0; i < 255; i++) begin
      step(1'b1, int'($urandom), int'($urandom));
      if (i % 51 == 0 || i == 254) check("reset_hold", out_s(), 0);
    end

    // id 2: constant stream right after release.
    add(0, 3, 2, 0, 2);  add(0, 3, 2, 0, 2);  add(0, 3, 2, 6, 2);
    add(0, 3, 2, 12, 2); add(0, 3, 2, 18, 2); add(0, 3, 2, 24, 2);
    add(0, 3, 2, 24, 2); add(0, 3, 2, 24, 2);
    // id 6: one-cycle reset in steady state, then the same ramp and latency.
    add(1, 3, 2, 0, 6);
    add(0, 3, 2, 0, 6);  add(0, 3, 2, 0, 6);  add(0, 3, 2, 6, 6);
    add(0, 3, 2, 12, 6); add(0, 3, 2, 18, 6); add(0, 3, 2, 24, 6);
    add(0, 3, 2, 24, 6);
    // id 3: single signed pair and its window exit.
    add(1, 0, 0, 0, 3);
    add(0, -5, 7, 0, 3); add(0, 0, 0, 0, 3);
    add(0, 0, 0, -35, 3); add(0, 0, 0, -35, 3);
    add(0, 0, 0, -35, 3); add(0, 0, 0, -35, 3);
    add(0, 0, 0, 0, 3);  add(0, 0, 0, 0, 3);
    // id 4: positive saturation.
    add(1, 0, 0, 0, 4);
    add(0, -2048, -2048, 0, 4);       add(0, -2048, -2048, 0, 4);
    add(0, -2048, -2048, 4194304, 4); add(0, -2048, -2048, 8388607, 4);
    add(0, -2048, -2048, 8388607, 4); add(0, -2048, -2048, 8388607, 4);
    add(0, -2048, -2048, 8388607, 4);
    // id 5: negative saturation.
    add(1, 0, 0, 0, 5);
    add(0, -2048, 2047, 0, 5);        add(0, -2048, 2047, 0, 5);
    add(0, -2048, 2047, -4192256, 5); add(0, -2048, 2047, -8384512, 5);
    add(0, -2048, 2047, -8388608, 5); add(0, -2048, 2047, -8388608, 5);
    add(0, -2048, 2047, -8388608, 5);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_id%0d", i, vecs[i].id), out_s(), longint'(vecs[i].exp));
    end

    // Randomized stream with occasional resets and extreme values.
    step(1'b1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int a;
      int b;
      logic r;
      r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? -2048 : 2047;
        b = ($urandom_range(0, 1) == 1) ? -2048 : 2047;
      end else begin
        a = $urandom_range(0, 4095) - 2048;
        b = $urandom_range(0, 4095) - 2048;
      end
      step(r, a, b);
      check($sformatf("rand%0d", i), out_s(), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
